// File: rtl/fir_decim_fifo.sv
// Decimating requantizer behind the FIR: keeps one valid sample in DECIM, rounds
// half-up with saturation to the output Q format, and buffers results in a FWFT FIFO.
module fir_decim_fifo #(
  parameter int IN_INTE_WL  = 4,
  parameter int IN_FRAC_WL  = 8,
  parameter int OUT_INTE_WL = 4,
  parameter int OUT_FRAC_WL = 6,
  parameter int DECIM       = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic signed [IN_INTE_WL+IN_FRAC_WL-1:0]  data_in,
  input  logic                                     in_valid,
  output logic signed [OUT_INTE_WL+OUT_FRAC_WL-1:0] out_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [$clog2(FIFO_DEPTH):0]              fifo_count,
  output logic                                     overflow
);

  localparam int IW = IN_INTE_WL + IN_FRAC_WL;
  localparam int OW = OUT_INTE_WL + OUT_FRAC_WL;
  localparam int S  = IN_FRAC_WL - OUT_FRAC_WL;
  localparam int XW = IW + OW + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [XW-1:0] RND =
    (S > 0) ? (XW'(1) << ((S > 0) ? S - 1 : 0)) : '0;
  localparam logic signed [XW-1:0] Q_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] Q_MIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [PW-1:0]        phase;
  logic                 keep;
  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] shifted;
  logic [OW-1:0]        quant;
  logic [OW-1:0]        s1_data;
  logic                 s1_push;
  logic [OW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 pop;
  logic                 wr;

  assign keep = in_valid && (phase == '0);

  // Working width leaves headroom for the rounding add, so saturation sees its carry.
  always_comb begin
    ext     = {{(XW-IW){data_in[IW-1]}}, data_in};
    shifted = (ext + RND) >>> S;
    if (shifted > Q_MAX)      quant = Q_MAX[OW-1:0];
    else if (shifted < Q_MIN) quant = Q_MIN[OW-1:0];
    else                      quant = shifted[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= '0;
      s1_push <= 1'b0;
      s1_data <= '0;
    end else begin
      if (in_valid) phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
      s1_push <= keep;
      if (keep) s1_data <= quant;
    end
  end

  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign wr        = s1_push && (!full || pop);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= s1_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !wr) fifo_count <= fifo_count - CW'(1);
      if (s1_push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo: rounding/saturation table, decimation streams,
// overflow, full push+pop and asynchronous reset sequences.
module tb_fir_decim_fifo;

  localparam int DECIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] data_in;
  logic        in_valid;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_count;
  logic        overflow;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [11:0] din;
    logic [9:0]  q;
  } vec_t;

  vec_t        vecs [6];
  logic [9:0]  hand [4];
  logic [9:0]  rx_v [$];

  always #5 clk = ~clk;

  fir_decim_fifo #(
    .IN_INTE_WL (4),
    .IN_FRAC_WL (8),
    .OUT_INTE_WL(4),
    .OUT_FRAC_WL(6),
    .DECIM      (DECIM),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Q4.8 -> Q4.6 reference: add half an output LSB, floor, clamp to 10-bit signed.
  function automatic logic [9:0] rq(input logic [11:0] x);
    int v;
    v = int'($signed(x));
    v = (v + 2) >>> 2;
    if (v > 511)  v = 511;
    if (v < -512) v = -512;
    return 10'(v);
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // Drives n cycles (in_valid from mask), then 4 idle cycles, with out_ready held high;
  // expects each kept sample exactly two edges after its drive cycle.
  task automatic run_stream(input logic [63:0] mask, input int n);
    int          ph;
    int          exp_t [$];
    logic [9:0]  exp_v [$];
    int          rx_t  [$];
    logic [11:0] d;
    ph = 0;
    rx_v.delete();
    for (int c = 0; c < n + 4; c++) begin
      d        = 12'(4 * c);
      in_valid = (c < n) ? mask[c] : 1'b0;
      data_in  = d;
      if (in_valid) begin
        if (ph == 0) begin
          exp_t.push_back(c + 2);
          exp_v.push_back(rq(d));
        end
        ph = (ph == DECIM - 1) ? 0 : ph + 1;
      end
      step();
      if (out_valid) begin
        rx_t.push_back(c + 1);
        rx_v.push_back(out_data);
      end
    end
    check("stream_count", rx_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < rx_t.size(); i++) begin
      check("stream_time", rx_t[i], exp_t[i]);
      check("stream_data", rx_v[i], exp_v[i]);
    end
  endtask

  initial begin
    vecs[0] = '{12'h103, 10'h041};
    vecs[1] = '{12'h100, 10'h040};
    vecs[2] = '{12'h002, 10'h001};
    vecs[3] = '{12'hFFE, 10'h000};
    vecs[4] = '{12'h7FF, 10'h1FF};
    vecs[5] = '{12'h800, 10'h200};
    hand    = '{10'h000, 10'h004, 10'h008, 10'h00C};

    // Reset held with toggling input activity
    rst = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      data_in  = 12'h7FF ^ 12'(c);
      step();
      check("rst_valid", out_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ovf", overflow, 0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) step();
    check("idle_valid", out_valid, 0);
    check("idle_count", fifo_count, 0);
    check("idle_ovf", overflow, 0);
    check("idle_data", out_data, 0);

    // Rounding and saturation table; three discarded valids realign the phase each time
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      data_in  = vecs[i].din;
      step();
      check("lat_early", out_valid, 0);
      data_in = 12'h7FF;
      step();
      check("lat_valid", out_valid, 1);
      check("rq_data", out_data, vecs[i].q);
      step();
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) step();
      check("rq_drained", out_valid, 0);
      check("rq_count", fifo_count, 0);
    end

    // Continuous decimation, then the same with valid gaps
    run_stream('1, 16);
    for (int i = 0; i < 4 && i < rx_v.size(); i++) check("decim_hand", rx_v[i], hand[i]);
    run_stream(64'h0000_0000_00A5_6D39, 24);

    // Backpressure: 10 kept into an 8-deep FIFO
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1;
      data_in  = 12'(4 * c);
      step();
      if (c == 32) begin
        check("ovf_before", overflow, 0);
        check("count_full", fifo_count, 8);
      end
    end
    in_valid = 1'b0;
    step();
    step();
    check("bp_count", fifo_count, 8);
    check("bp_ovf", overflow, 1);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, 10'(4 * i));
      step();
    end
    check("drain_empty", out_valid, 0);
    check("drain_count", fifo_count, 0);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with a push and pop on the same edge
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 36; c++) begin
      out_ready = (c == 33);
      in_valid  = 1'b1;
      data_in   = 12'(4 * c);
      step();
      if (c == 33) begin
        check("pp_count", fifo_count, 8);
        check("pp_ovf", overflow, 0);
        check("pp_head", out_data, 10'h004);
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    step();
    check("pp_count_end", fifo_count, 8);
    check("pp_ovf_end", overflow, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pp_drain", out_data, 10'(4 * (i + 1)));
      step();
    end
    check("pp_empty", out_valid, 0);

    // Refill partially, then reset between clock edges
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      data_in  = 12'(4 * c + 64);
      step();
    end
    check("refill_count", fifo_count, 3);
    check("refill_valid", out_valid, 1);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_count", fifo_count, 0);
    check("async_ovf", overflow, 0);
    check("async_data", out_data, 0);
    step();
    check("held_count", fifo_count, 0);
    rst = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
